// File: rtl/sequential_divider_32x16_if.sv
// Handshake and data bundle between the datapath controller and the divider.
//   master : controller side, drives start/dividend/divisor and observes results
//   slave  : divider side, samples operands and drives ready/done/results/flags
interface sequential_divider_32x16_if #(
    parameter int unsigned DIVIDEND_W = 32,
    parameter int unsigned DIVISOR_W  = 16
);
    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  ready;
    logic                  done;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;
    logic                  check_err;

    modport master (
        output start, dividend, divisor,
        input  ready, done, quotient, remainder, div_by_zero, check_err
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, done, quotient, remainder, div_by_zero, check_err
    );
endinterface

// File: rtl/sequential_divider_32x16.sv
// Multi-cycle unsigned restoring divider: DIVIDEND_W-bit dividend by DIVISOR_W-bit
// divisor, one quotient bit per clock, start/ready/done handshake.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave modport carrying start/dividend/divisor in and
//           ready/done/quotient/remainder/div_by_zero/check_err out
// Optional macro SEQ_DIV_SELF_CHECK_EN adds a q*d+r == dividend, r < d checker
// driving check_err; without it check_err is constant 0.
module sequential_divider_32x16 #(
    parameter int unsigned DIVIDEND_W = 32,
    parameter int unsigned DIVISOR_W  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    sequential_divider_32x16_if.slave   bus
);
    localparam int unsigned CNT_W  = $clog2(DIVIDEND_W);
    localparam int unsigned TRIAL_W = DIVISOR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [DIVIDEND_W-1:0] shift_q, shift_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIVISOR_W-1:0]  dvsr_q, dvsr_d;
    logic                  dz_q, dz_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic [DIVIDEND_W-1:0] quot_q, quot_d;
    logic [DIVISOR_W-1:0]  remo_q, remo_d;
    logic                  dzo_q, dzo_d;

    logic [TRIAL_W-1:0]    trial;
    logic [TRIAL_W-1:0]    dvsr_ext;
    logic                  ge;

`ifdef SEQ_DIV_SELF_CHECK_EN
    localparam int unsigned PROD_W = DIVIDEND_W + DIVISOR_W;
    logic [DIVIDEND_W-1:0] dvnd_q, dvnd_d;
    logic                  chk_q, chk_d;
    logic [PROD_W-1:0]     recon;
    logic                  chk_fail;

    // Reconstruct the dividend from the final quotient/remainder.
    always_comb begin
        recon    = PROD_W'(shift_q) * PROD_W'(dvsr_q) + PROD_W'(rem_q);
        chk_fail = (recon != PROD_W'(dvnd_q)) || (rem_q >= dvsr_q);
    end
`endif

    // One restoring step: bring in the next dividend bit and trial-subtract.
    always_comb begin
        trial    = {rem_q, shift_q[DIVIDEND_W-1]};
        dvsr_ext = {1'b0, dvsr_q};
        ge       = (trial >= dvsr_ext);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        dvsr_d  = dvsr_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dzo_d   = dzo_q;
`ifdef SEQ_DIV_SELF_CHECK_EN
        dvnd_d  = dvnd_q;
        chk_d   = chk_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    dvsr_d = bus.divisor;
                    dzo_d  = 1'b0;
`ifdef SEQ_DIV_SELF_CHECK_EN
                    dvnd_d = bus.dividend;
                    chk_d  = 1'b0;
`endif
                    if (bus.divisor != '0) begin
                        shift_d = bus.dividend;
                        rem_d   = '0;
                        cnt_d   = CNT_W'(DIVIDEND_W - 1);
                        dz_d    = 1'b0;
                        state_d = S_RUN;
                    end else begin
                        // Divide by zero: saturate quotient, pass low dividend bits through.
                        shift_d = '1;
                        rem_d   = bus.dividend[DIVISOR_W-1:0];
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                shift_d = {shift_q[DIVIDEND_W-2:0], ge};
                rem_d   = ge ? DIVISOR_W'(trial - dvsr_ext) : trial[DIVISOR_W-1:0];
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                quot_d  = shift_q;
                remo_d  = rem_q;
                dzo_d   = dz_q;
`ifdef SEQ_DIV_SELF_CHECK_EN
                chk_d   = !dz_q && chk_fail;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    // State and output registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            dvsr_q  <= '0;
            dz_q    <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            dzo_q   <= 1'b0;
`ifdef SEQ_DIV_SELF_CHECK_EN
            dvnd_q  <= '0;
            chk_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            dvsr_q  <= dvsr_d;
            dz_q    <= dz_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dzo_q   <= dzo_d;
`ifdef SEQ_DIV_SELF_CHECK_EN
            dvnd_q  <= dvnd_d;
            chk_q   <= chk_d;
`endif
        end
    end

    assign bus.ready       = ready_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = remo_q;
    assign bus.div_by_zero = dzo_q;
`ifdef SEQ_DIV_SELF_CHECK_EN
    assign bus.check_err   = chk_q;
`else
    assign bus.check_err   = 1'b0;
`endif
endmodule

// File: tb/tb_sequential_divider_32x16.sv
// Directed and randomized checks of sequential_divider_32x16 against hand values
// and a behavioural / % model.
module tb_sequential_divider_32x16;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    sequential_divider_32x16_if #(.DIVIDEND_W(32), .DIVISOR_W(16)) bus ();

    sequential_divider_32x16 #(.DIVIDEND_W(32), .DIVISOR_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request and wait for done; lat = edges from accept to the done cycle.
    task automatic run_op(input logic [31:0] dvd, input logic [15:0] dvs, output int lat);
        bit got;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = ~dvd;
        bus.divisor  = ~dvs;
        lat = 0;
        got = 1'b0;
        while (lat < 100 && !got) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.done) got = 1'b1;
        end
        if (!got) check("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int          lat;
        int          dones;
        int          ready_hi;
        logic [31:0] a;
        logic [15:0] b;
        logic [31:0] eq;
        logic [15:0] er;

        n_checks = 0;
        n_fails  = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(bus.ready), 64'd1);
        check("rst_done",  64'(bus.done), 64'd0);
        check("rst_quot",  64'(bus.quotient), 64'd0);
        check("rst_rem",   64'(bus.remainder), 64'd0);
        check("rst_dz",    64'(bus.div_by_zero), 64'd0);
        check("rst_chk",   64'(bus.check_err), 64'd0);
        rst_n = 1'b1;

        // 100 / 7
        run_op(32'd100, 16'd7, lat);
        check("t1_lat",  64'(lat), 64'd33);
        check("t1_quot", 64'(bus.quotient), 64'd14);
        check("t1_rem",  64'(bus.remainder), 64'd2);
        check("t1_dz",   64'(bus.div_by_zero), 64'd0);
        check("t1_rdy",  64'(bus.ready), 64'd1);
        @(negedge clk);
        check("t1_pulse", 64'(bus.done), 64'd0);
        check("t1_hold",  64'(bus.quotient), 64'd14);

        // Max / max
        run_op(32'hFFFF_FFFF, 16'hFFFF, lat);
        check("t2_quot", 64'(bus.quotient), 64'h0001_0001);
        check("t2_rem",  64'(bus.remainder), 64'h0);

        // Divide by zero
        run_op(32'h0000_04D2, 16'h0000, lat);
        check("t3_lat",  64'(lat), 64'd1);
        check("t3_quot", 64'(bus.quotient), 64'hFFFF_FFFF);
        check("t3_rem",  64'(bus.remainder), 64'h04D2);
        check("t3_dz",   64'(bus.div_by_zero), 64'd1);
        @(negedge clk);
        check("t3_dz_hold", 64'(bus.div_by_zero), 64'd1);

        // Start held high with changing operands: only the first request counts
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd1000;
        bus.divisor  = 16'd3;
        @(posedge clk);
        dones    = 0;
        ready_hi = 0;
        lat      = 0;
        while (lat < 100 && dones == 0) begin
            #1;
            bus.dividend = 32'd5000 + 32'(lat);
            bus.divisor  = 16'd9;
            @(negedge clk);
            if (bus.done) dones++;
            else if (bus.ready) ready_hi++;
            if (dones == 0) begin
                @(posedge clk);
                lat++;
            end
        end
        bus.start = 1'b0;
        check("t4_lat",   64'(lat), 64'd33);
        check("t4_dones", 64'(dones), 64'd1);
        check("t4_ready", 64'(ready_hi), 64'd0);
        check("t4_quot",  64'(bus.quotient), 64'd333);
        check("t4_rem",   64'(bus.remainder), 64'd1);
        check("t4_dz",    64'(bus.div_by_zero), 64'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("t4_no_extra", 64'(dones), 64'd0);

        // Reset on edge 10 of a run
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd99999;
        bus.divisor  = 16'd17;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_ready", 64'(bus.ready), 64'd1);
        check("t5_quot",  64'(bus.quotient), 64'd0);
        check("t5_rem",   64'(bus.remainder), 64'd0);
        check("t5_done",  64'(bus.done), 64'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("t5_no_done", 64'(dones), 64'd0);
        run_op(32'd12345, 16'd100, lat);
        check("t5_lat",  64'(lat), 64'd33);
        check("t5_quot", 64'(bus.quotient), 64'd123);
        check("t5_rem",  64'(bus.remainder), 64'd45);

        // Randomized pairs against the model, with forced corner cases
        for (int i = 0; i < 2000; i++) begin
            a = $urandom();
            b = 16'($urandom());
            case (i % 8)
                0: b = 16'd1;
                1: begin b = 16'($urandom_range(2, 65535)); a = 32'($urandom_range(0, 32'(b) - 1)); end
                2: a = a >> $urandom_range(0, 31);
                3: b = b >> $urandom_range(0, 15);
                default: ;
            endcase
            if (i == 1000) b = 16'd0;
            if (b == 16'd0) begin
                eq = 32'hFFFF_FFFF;
                er = a[15:0];
            end else begin
                eq = a / 32'(b);
                er = 16'(a % 32'(b));
            end
            run_op(a, b, lat);
            check("rnd_quot", 64'(bus.quotient), 64'(eq));
            check("rnd_rem",  64'(bus.remainder), 64'(er));
            check("rnd_dz",   64'(bus.div_by_zero), 64'(b == 16'd0));
            check("rnd_chk",  64'(bus.check_err), 64'd0);
        end

`ifdef SEQ_DIV_SELF_CHECK_EN
        // Corrupt the partial remainder just before results are registered
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd100;
        bus.divisor  = 16'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (32) @(posedge clk);
        #1 force dut.rem_q = 16'hFFFF;
        @(posedge clk);
        #1 release dut.rem_q;
        @(negedge clk);
        check("sc_done", 64'(bus.done), 64'd1);
        check("sc_err",  64'(bus.check_err), 64'd1);
        run_op(32'd100, 16'd7, lat);
        check("sc_clear", 64'(bus.check_err), 64'd0);
        check("sc_quot",  64'(bus.quotient), 64'd14);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
